// File: rtl/issue_queue_pkg.sv
// Shared definitions for the issue queue: entry field offsets and physical-register sizes.
package issue_queue_pkg;

    localparam int ENTRY_W  = 186;
    localparam int PREG_W   = 6;
    localparam int NUM_PREG = 64;

    localparam int CTRL_HI  = 185;
    localparam int CTRL_LO  = 82;
    localparam int INSTR_HI = 81;
    localparam int INSTR_LO = 50;
    localparam int PC_HI    = 49;
    localparam int PC_LO    = 18;
    localparam int MAPC_LO  = 12;
    localparam int MAPB_LO  = 6;
    localparam int MAPA_LO  = 0;

    // Control bit 97 of the entry marks an immediate second operand.
    localparam int HAS_IMM_BIT = 179;

    typedef logic [PREG_W-1:0] preg_t;

    function automatic preg_t entry_tag(input logic [ENTRY_W-1:0] e, input int lo);
        return e[lo +: PREG_W];
    endfunction

endpackage

// File: rtl/issue_select.sv
// Lowest-index fixed-priority selector: one-hot grant of the oldest requesting slot.
module issue_select #(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant,
    output logic             found
);

    // Two's-complement isolation of the lowest set bit.
    assign grant = req & (~req + DEPTH'(1));
    assign found = |req;

endmodule

// File: rtl/issue_queue.sv
// Compacting age-ordered issue queue; slot 0 is the oldest entry.
// Optional same-cycle wakeup from the EXE broadcast: ISSUE_WAKEUP_BYPASS_EN.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                STALL,
    input  logic                FLUSH,
    input  logic                entry_allocate_issue,
    input  logic [ENTRY_W-1:0]  entry_issue,
    input  logic [NUM_PREG-1:0] busy,
    input  logic                exe_busyclear_flag,
    input  logic [PREG_W-1:0]   exe_busyclear_reg,
    input  logic                exe_ready,
    output logic                issue_valid,
    output logic [ENTRY_W-1:0]  issue_entry,
    output logic                issue_halt,
    output logic [CW-1:0]       occupancy
);

    logic [CW-1:0]      count_q;
    logic [ENTRY_W-1:0] slot_q [DEPTH];
    logic [ENTRY_W-1:0] slot_d [DEPTH];
    logic [ENTRY_W-1:0] above  [DEPTH];
    logic [DEPTH-1:0]   req;
    logic [DEPTH-1:0]   grant;
    logic [DEPTH-1:0]   shift_mask;
    logic               found;
    logic               do_issue;
    logic               do_alloc;
    logic [CW-1:0]      wr_idx;

    function automatic logic src_ready(input preg_t tag);
        logic r;
        r = !busy[tag];
`ifdef ISSUE_WAKEUP_BYPASS_EN
        if (exe_busyclear_flag && (exe_busyclear_reg == tag)) r = 1'b1;
`else
        if (exe_busyclear_flag && (exe_busyclear_reg == tag)) r = !busy[tag];
`endif
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            req[i] = (CW'(i) < count_q)
                  && src_ready(entry_tag(slot_q[i], MAPA_LO))
                  && (slot_q[i][HAS_IMM_BIT] || src_ready(entry_tag(slot_q[i], MAPB_LO)));
        end
    end

    issue_select #(.DEPTH(DEPTH)) u_select (
        .req   (req),
        .grant (grant),
        .found (found)
    );

    // Payload mux and the "at or above the issued slot" mask used for compaction.
    always_comb begin
        logic acc;
        acc         = 1'b0;
        issue_entry = '0;
        shift_mask  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            issue_entry   = issue_entry | ({ENTRY_W{grant[i]}} & slot_q[i]);
            acc           = acc | grant[i];
            shift_mask[i] = acc;
        end
    end

    assign issue_halt  = (count_q == CW'(DEPTH)) || STALL;
    assign issue_valid = found && !STALL && !FLUSH;
    assign do_issue    = issue_valid && exe_ready;
    assign do_alloc    = entry_allocate_issue && !issue_halt && !FLUSH;
    assign wr_idx      = count_q - CW'(do_issue);
    assign occupancy   = count_q;

    // Next slot contents: shift down past the issued slot, then drop the new entry at the tail.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) above[i] = slot_q[i + 1];
        above[DEPTH-1] = slot_q[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i];
            if (do_issue && shift_mask[i]) slot_d[i] = above[i];
            if (do_alloc && (wr_idx == CW'(i))) slot_d[i] = entry_issue;
        end
    end

    always_ff @(posedge CLK) begin
        slot_q <= slot_d;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
        end else if (FLUSH) begin
            count_q <= '0;
        end else if (!STALL) begin
            count_q <= count_q + CW'(do_alloc) - CW'(do_issue);
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: queue-based reference model, randomized and directed traffic.
module tb_issue_queue;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK;
    logic          RESET;
    logic          STALL;
    logic          FLUSH;
    logic          entry_allocate_issue;
    logic [185:0]  entry_issue;
    logic [63:0]   busy;
    logic          exe_busyclear_flag;
    logic [5:0]    exe_busyclear_reg;
    logic          exe_ready;
    logic          issue_valid;
    logic [185:0]  issue_entry;
    logic          issue_halt;
    logic [CW-1:0] occupancy;

    int checks = 0;
    int errors = 0;

    logic [185:0] mq [$];   // model queue, oldest first
    logic [185:0] sb [$];   // expected issued payloads, in order

    issue_queue #(.DEPTH(DEPTH)) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .STALL                (STALL),
        .FLUSH                (FLUSH),
        .entry_allocate_issue (entry_allocate_issue),
        .entry_issue          (entry_issue),
        .busy                 (busy),
        .exe_busyclear_flag   (exe_busyclear_flag),
        .exe_busyclear_reg    (exe_busyclear_reg),
        .exe_ready            (exe_ready),
        .issue_valid          (issue_valid),
        .issue_entry          (issue_entry),
        .issue_halt           (issue_halt),
        .occupancy            (occupancy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #400000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic logic [185:0] mk(input logic [5:0] a, input logic [5:0] b, input logic imm);
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        r[5:0]   = a;
        r[11:6]  = b;
        r[179]   = imm;
        return r[185:0];
    endfunction

    function automatic bit op_ready(input logic [5:0] tag, input logic [63:0] bz,
                                    input logic bf, input logic [5:0] br);
        bit r;
        r = (bz[tag] == 1'b0);
`ifdef ISSUE_WAKEUP_BYPASS_EN
        if (bf && br == tag) r = 1'b1;
`endif
        return r;
    endfunction

    function automatic bit entry_ready(input logic [185:0] e, input logic [63:0] bz,
                                       input logic bf, input logic [5:0] br);
        return op_ready(e[5:0], bz, bf, br) && (e[179] || op_ready(e[11:6], bz, bf, br));
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock cycle, entered and left 1 time unit after a rising edge.
    task automatic step(input logic al, input logic [185:0] ent, input logic [63:0] bz,
                        input logic bf, input logic [5:0] br, input logic er,
                        input logic st, input logic fl);
        int  idx;
        bit  full;
        entry_allocate_issue = al;
        entry_issue          = ent;
        busy                 = bz;
        exe_busyclear_flag   = bf;
        exe_busyclear_reg    = br;
        exe_ready            = er;
        STALL                = st;
        FLUSH                = fl;
        #1;
        idx = -1;
        if (!st && !fl) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (entry_ready(mq[i], bz, bf, br)) begin
                    idx = i;
                    break;
                end
            end
        end
        full = (mq.size() == DEPTH);
        chk("occupancy", 192'(occupancy), 192'(mq.size()));
        chk("issue_halt", 192'(issue_halt), 192'(full || st));
        chk("issue_valid", 192'(issue_valid), 192'(idx >= 0));
        if (idx >= 0 && er) sb.push_back(mq[idx]);
        @(posedge CLK);
        if (fl) begin
            mq.delete();
        end else if (!st) begin
            if (idx >= 0 && er) mq.delete(idx);
            if (al && !full) mq.push_back(ent);
        end
        #1;
    endtask

    task automatic idle(input int n, input logic er);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, er, 1'b0, 1'b0);
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, mk(6'($urandom), 6'($urandom), 1'($urandom)), '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_mid();
        RESET                = 1'b1;
        entry_allocate_issue = 1'b0;
        STALL                = 1'b0;
        FLUSH                = 1'b0;
        exe_ready            = 1'b1;
        #1;
        chk("rst_occupancy", 192'(occupancy), 192'(0));
        chk("rst_issue_valid", 192'(issue_valid), 192'(0));
        chk("rst_issue_halt", 192'(issue_halt), 192'(0));
        chk("rst_issue_entry", 192'(issue_entry), 192'(0));
        mq.delete();
        #2;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    // Monitor: pops the scoreboard on every accepted issue, just before the edge.
    initial begin
        logic [185:0] exp;
        forever begin
            @(negedge CLK);
            #4;
            if (!RESET && issue_valid && exe_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue actual=%0h required=none", issue_entry);
                end else begin
                    exp = sb.pop_front();
                    chk("issue_entry", 192'(issue_entry), 192'(exp));
                end
            end
        end
    end

    initial begin
        logic [185:0] x;
        logic [185:0] y;
        logic [63:0]  bz;
        int           guard;

        RESET = 1'b1;
        STALL = 1'b0;
        FLUSH = 1'b0;
        entry_allocate_issue = 1'b0;
        entry_issue = '0;
        busy = '0;
        exe_busyclear_flag = 1'b0;
        exe_busyclear_reg = '0;
        exe_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_occupancy", 192'(occupancy), 192'(0));
        chk("reset_issue_valid", 192'(issue_valid), 192'(0));
        chk("reset_issue_halt", 192'(issue_halt), 192'(0));
        chk("reset_issue_entry", 192'(issue_entry), 192'(0));
        #2;
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        // Basic allocate then issue one cycle later.
        step(1'b1, mk(6'd3, 6'd4, 1'b0), '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);

        // Blocked older entry X, younger ready Y issues first; wakeup of X.
        bz = 64'h20;
        x  = mk(6'd5, 6'd1, 1'b0);
        y  = mk(6'd2, 6'd1, 1'b0);
        step(1'b1, x, bz, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, y, bz, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, bz, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, bz, 1'b1, 6'd5, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);

        // Immediate B operand ignores a busy MAPB.
        step(1'b1, mk(6'd2, 6'd9, 1'b1), 64'h200, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 64'h200, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);

        // Full boundary: 17 allocates with EXE closed, then drain in order.
        fill(17);
        step(1'b1, mk(6'd1, 6'd1, 1'b0), '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, mk(6'd1, 6'd1, 1'b0), '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(20, 1'b1);

        // Concurrent allocate and issue at count 8.
        fill(8);
        step(1'b1, mk(6'd7, 6'd7, 1'b0), '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        idle(12, 1'b1);

        // Flush with a concurrent allocate, then flush under stall.
        fill(10);
        step(1'b1, mk(6'd1, 6'd2, 1'b0), '0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);
        fill(4);
        step(1'b1, mk(6'd1, 6'd2, 1'b0), '0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Reset asserted mid-stream.
        fill(5);
        reset_mid();
        idle(2, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 9) < 7),
                 mk(6'($urandom), 6'($urandom), 1'($urandom)),
                 {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom},
                 1'($urandom_range(0, 9) < 3),
                 6'($urandom),
                 1'($urandom_range(0, 9) < 5),
                 1'($urandom_range(0, 99) < 5),
                 1'($urandom_range(0, 99) < 2));
        end

        guard = 0;
        while (mq.size() != 0 && guard < 64) begin
            idle(1, 1'b1);
            guard++;
        end
        chk("drain_empty", 192'(mq.size()), 192'(0));
        idle(1, 1'b1);
        chk("scoreboard_empty", 192'(sb.size()), 192'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
